msi_bus_ctrl: RTL

Two-processor snooping bus responder for the MSI data caches. It receives coherence requests from both `cache_controller` instances: `read_miss`, `write_miss`, `invalidate`, and the BICO address. For each request it snoops the opposite cache, returns the data source and any forwarded word, and broadcasts invalidations. Independently, it arbitrates both caches' unified-memory requests (`u_re`/`u_we`) and drives each cache's `grant`.

---
 rtl/msi_bus_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/msi_bus_ctrl.sv
// Snooping bus responder for two MSI data caches: serialises coherence requests
// (snoop, forward, invalidate) and arbitrates the shared unified-memory port.
module msi_bus_ctrl #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_miss0,
    input  logic              read_miss1,
    input  logic              write_miss0,
    input  logic              write_miss1,
    input  logic              invalidate0,
    input  logic              invalidate1,
    input  logic [ADDR_W-1:0] BICO0,
    input  logic [ADDR_W-1:0] BICO1,
    input  logic              u_re0,
    input  logic              u_re1,
    input  logic              u_we0,
    input  logic              u_we1,
    input  logic              cpu_search_found0,
    input  logic              cpu_search_found1,
    input  logic [15:0]       send_other_proc_data0,
    input  logic [15:0]       send_other_proc_data1,
    output logic              grant0,
    output logic              grant1,
    output logic [ADDR_W-1:0] BOCI0,
    output logic [ADDR_W-1:0] BOCI1,
    output logic              cpu_search0,
    output logic              cpu_search1,
    output logic              invalidate_from_other_cpu0,
    output logic              invalidate_from_other_cpu1,
    output logic [1:0]        cpu_datasel0,
    output logic [1:0]        cpu_datasel1,
    output logic [15:0]       other_proc_data0,
    output logic [15:0]       other_proc_data1,
    output logic              resp_valid0,
    output logic              resp_valid1,
    output logic              busy
);

    typedef enum logic [1:0] {REQ_READ, REQ_WRITE, REQ_INVAL} req_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SNOOP, ST_RESP, ST_INVAL} state_t;
    typedef enum logic [1:0] {MEM_NONE, MEM_CPU0, MEM_CPU1} mem_t;

    state_t            state_reg;
    logic              owner_reg;
    logic              rr_c_reg;
    logic [1:0]        cpu_search_reg;
    logic [1:0]        inval_reg;
    logic [1:0]        resp_valid_reg;
    logic [ADDR_W-1:0] boci_reg [2];

    logic [1:0]        rd_pulse;
    logic [1:0]        wr_pulse;
    logic [1:0]        inv_pulse;
    logic [1:0]        any_pulse;
    logic [1:0]        pend_valid;
    logic [1:0]        pend_clear;
    req_t              pulse_type [2];
    req_t              pend_type  [2];
    logic [ADDR_W-1:0] bico       [2];
    logic [ADDR_W-1:0] pend_addr  [2];

    logic              pick;
    logic              pick_other;
    logic              other;
    logic              resp_phase;
    logic [1:0]        fwd;

    mem_t              mem_owner_reg;
    logic              rr_m_reg;
    logic [1:0]        mem_req;

    assign rd_pulse  = {read_miss1, read_miss0};
    assign wr_pulse  = {write_miss1, write_miss0};
    assign inv_pulse = {invalidate1, invalidate0};
    assign bico[0]   = BICO0;
    assign bico[1]   = BICO1;

    // A pending slot accepts a pulse only when empty or being retired this cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_pend
            logic              valid_reg;
            req_t              type_reg;
            logic [ADDR_W-1:0] addr_reg;

            assign any_pulse[gi]  = rd_pulse[gi] | wr_pulse[gi] | inv_pulse[gi];
            assign pulse_type[gi] = wr_pulse[gi] ? REQ_WRITE :
                                    (rd_pulse[gi] ? REQ_READ : REQ_INVAL);
            assign pend_clear[gi] = ((state_reg == ST_RESP) || (state_reg == ST_INVAL)) &&
                                    (owner_reg == 1'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    type_reg  <= REQ_READ;
                    addr_reg  <= '0;
                end else if (pend_clear[gi] || !valid_reg) begin
                    valid_reg <= any_pulse[gi];
                    if (any_pulse[gi]) begin
                        type_reg <= pulse_type[gi];
                        addr_reg <= bico[gi];
                    end
                end
            end

            assign pend_valid[gi] = valid_reg;
            assign pend_type[gi]  = type_reg;
            assign pend_addr[gi]  = addr_reg;
        end
    endgenerate

    assign pick       = (&pend_valid) ? rr_c_reg : pend_valid[1];
    assign pick_other = ~pick;
    assign other      = ~owner_reg;

    // Strobes and BOCI are registered: each is loaded on the edge entering its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            rr_c_reg       <= 1'b0;
            cpu_search_reg <= '0;
            inval_reg      <= '0;
            resp_valid_reg <= '0;
            boci_reg[0]    <= '0;
            boci_reg[1]    <= '0;
        end else begin
            cpu_search_reg <= '0;
            inval_reg      <= '0;
            resp_valid_reg <= '0;
            boci_reg[0]    <= '0;
            boci_reg[1]    <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (|pend_valid) begin
                        owner_reg            <= pick;
                        boci_reg[pick_other] <= pend_addr[pick];
                        if (pend_type[pick] == REQ_INVAL) begin
                            state_reg                  <= ST_INVAL;
                            inval_reg[pick_other]      <= 1'b1;
                            resp_valid_reg[pick]       <= 1'b1;
                        end else begin
                            state_reg                  <= ST_SNOOP;
                            cpu_search_reg[pick_other] <= 1'b1;
                        end
                    end
                end
                ST_SNOOP: begin
                    state_reg                 <= ST_RESP;
                    boci_reg[other]           <= pend_addr[owner_reg];
                    resp_valid_reg[owner_reg] <= 1'b1;
                    if (pend_type[owner_reg] == REQ_WRITE)
                        inval_reg[other] <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    rr_c_reg  <= other;
                end
            endcase
        end
    end

    // The snooped cache answers during RESP, so the fill source is muxed live.
    assign resp_phase = (state_reg == ST_RESP);
    assign fwd[0]     = resp_phase && !owner_reg && cpu_search_found1;
    assign fwd[1]     = resp_phase &&  owner_reg && cpu_search_found0;

    assign cpu_datasel0     = fwd[0] ? 2'b01 : 2'b00;
    assign cpu_datasel1     = fwd[1] ? 2'b01 : 2'b00;
    assign other_proc_data0 = fwd[0] ? send_other_proc_data1 : 16'h0000;
    assign other_proc_data1 = fwd[1] ? send_other_proc_data0 : 16'h0000;

    assign BOCI0                      = boci_reg[0];
    assign BOCI1                      = boci_reg[1];
    assign cpu_search0                = cpu_search_reg[0];
    assign cpu_search1                = cpu_search_reg[1];
    assign invalidate_from_other_cpu0 = inval_reg[0];
    assign invalidate_from_other_cpu1 = inval_reg[1];
    assign resp_valid0                = resp_valid_reg[0];
    assign resp_valid1                = resp_valid_reg[1];
    assign busy                       = (state_reg != ST_IDLE) || (|pend_valid);

    // Ownership persists while either request level is held, so evict-then-fill stays atomic.
    assign mem_req = {u_re1 | u_we1, u_re0 | u_we0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_owner_reg <= MEM_NONE;
            rr_m_reg      <= 1'b0;
        end else begin
            case (mem_owner_reg)
                MEM_NONE: begin
                    if (&mem_req)
                        mem_owner_reg <= rr_m_reg ? MEM_CPU1 : MEM_CPU0;
                    else if (mem_req[1])
                        mem_owner_reg <= MEM_CPU1;
                    else if (mem_req[0])
                        mem_owner_reg <= MEM_CPU0;
                end
                MEM_CPU0: begin
                    if (!mem_req[0]) begin
                        mem_owner_reg <= MEM_NONE;
                        rr_m_reg      <= 1'b1;
                    end
                end
                MEM_CPU1: begin
                    if (!mem_req[1]) begin
                        mem_owner_reg <= MEM_NONE;
                        rr_m_reg      <= 1'b0;
                    end
                end
                default: mem_owner_reg <= MEM_NONE;
            endcase
        end
    end

    assign grant0 = (mem_owner_reg == MEM_CPU0) && mem_req[0];
    assign grant1 = (mem_owner_reg == MEM_CPU1) && mem_req[1];

endmodule
